// File: rtl/ricerca_binaria_pkg.sv
// Shared definitions for the successive-approximation search controller:
// default width and the 2-bit state encoding.
package ricerca_binaria_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROVA    = 2'd1,
    VERIFICA = 2'd2,
    FINE     = 2'd3
  } stato_t;

endpackage

// File: rtl/comparatore4.sv
// Combinational 4-bit magnitude comparator: exactly one of gt/eq/lt is high.
// Pure combinational path; no flow control.
module comparatore4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/ricerca_binaria.sv
// Closed-loop MSB-first search driving comparator A; one trial per clock,
// done 2..N+2 cycles after start is accepted; start is ignored while busy.
module ricerca_binaria
  import ricerca_binaria_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         gt,
  input  logic         eq,
  input  logic         lt,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         found,
  output logic         errore
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  stato_t        r_state;
  stato_t        w_next;
  logic [N-1:0]  r_guess;
  logic [N-1:0]  r_result;
  logic [IW-1:0] r_idx;
  logic          r_found;
  logic          r_errore;
  logic [N-1:0]  w_trial;
  logic          w_ok;

  assign w_ok = $onehot({gt, eq, lt});

  // Candidate for the next trial: resolve the current bit, then probe the next lower one.
  always_comb begin
    w_trial = r_guess;
    if (gt) begin
      w_trial[r_idx] = 1'b0;
    end
    if (r_idx != '0) begin
      w_trial[r_idx - IW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = PROVA;
        end
      end
      PROVA: begin
        if (!w_ok || eq) begin
          w_next = FINE;
        end else if (r_idx == '0) begin
          w_next = VERIFICA;
        end
      end
      VERIFICA: w_next = FINE;
      FINE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_guess  <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_found  <= 1'b0;
      r_errore <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_found  <= 1'b0;
            r_errore <= 1'b0;
            r_result <= '0;
            r_idx    <= IW'(N - 1);
            r_guess  <= {1'b1, {(N-1){1'b0}}};
          end
        end
        PROVA: begin
          if (!w_ok) begin
            r_errore <= 1'b1;
            r_found  <= 1'b0;
          end else if (eq) begin
            r_result <= r_guess;
            r_found  <= 1'b1;
          end else begin
            r_guess <= w_trial;
            if (r_idx != '0) begin
              r_idx <= r_idx - IW'(1);
            end
          end
        end
        VERIFICA: begin
          if (!w_ok) begin
            r_errore <= 1'b1;
            r_found  <= 1'b0;
          end else begin
            r_result <= r_guess;
            r_found  <= eq;
          end
        end
        FINE: begin
          r_guess <= '0;
        end
        default: begin
          r_guess <= '0;
        end
      endcase
    end
  end

  assign guess  = r_guess;
  assign result = r_result;
  assign found  = r_found;
  assign errore = r_errore;
  assign busy   = (r_state == PROVA) || (r_state == VERIFICA);
  assign done   = (r_state == FINE);

endmodule
